writeback_unit: RTL
===================

# writeback_unit

Writer-side companion to the CPU register file: it collects completed ALU results and in-order load responses, aligns and sign-extends load data, and drives the single register-file write port (`reg_wr`, `reg_wr_addr`, `reg_wr_data`). It keeps a small queue of outstanding loads, which doubles as a scoreboard so decode can stall on pending destinations. It sits between execute/memory and the register file.

## Interface
- `MAX_OUTSTANDING`, default 2: depth of the outstanding-load queue (legal values 1..8).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_result`  in  32  ALU result.
- `ld_issue_valid`  in  1  load sent to memory this cycle.
- `ld_issue_ready`  out  1  queue can take a load.
- `ld_issue_rd`  in  5  load destination.
- `ld_issue_funct3`  in  3  load type.
- `ld_issue_offset`  in  2  byte address bits [1:0].
- `mem_rsp_valid`  in  1  memory read data valid; in order; no backpressure.
- `mem_rsp_data`  in  32  raw aligned word.
- `sb_rs1_addr`, `sb_rs2_addr`  in  5 each  decode source registers.
- `sb_stall`  out  1  a source is pending.
- `reg_wr`  out  1  register-file write enable.
- `reg_wr_addr`  out  5  write address.
- `reg_wr_data`  out  32  write data.

## Operation
- Queue: FIFO of {rd, funct3, offset}. Push on `ld_issue_valid && ld_issue_ready`. Pop on `mem_rsp_valid` when not empty.
- `ld_issue_ready` = count < MAX_OUTSTANDING. A simultaneous push and pop is legal when the queue is not full. There is no pass-through when full.
- A `mem_rsp_valid` with an empty queue is ignored: no write and no state change.
- Arbitration: a load response always wins the write port.
- `alu_ready` = !mem_rsp_valid && !(alu_rd != 0 && alu_rd matches a queued entry). This blocks WAW hazards against pending loads.
- Load alignment, by funct3:
  - 000 LB: byte `offset`, sign-extended.
  - 001 LH: halfword `offset[1]`, sign-extended.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: as LB/LH, zero-extended.
  - LH/LHU ignore `offset[0]`; LW ignores `offset`.
  - 011/110/111: treated as LW.
- x0: a write with rd = 0 produces `reg_wr` = 0; address and data still update.
- Scoreboard: `sb_stall` = 1 when a nonzero rs1 or rs2 matches any valid queue entry. Without `WB_BYPASS_EN` it also asserts when the source matches `reg_wr_addr` while `reg_wr` = 1.

## Timing
- Write latency is 1 cycle: an ALU handshake or `mem_rsp_valid` at edge N gives `reg_wr`/`reg_wr_addr`/`reg_wr_data` valid after edge N. The register file commits at edge N+1.
- `reg_wr` = 0 in every cycle with no accepted source.
- Queue entries are visible to `sb_stall` the cycle after push and disappear the cycle after pop.
- `alu_ready` and `ld_issue_ready` are combinational from current inputs and state; `sb_stall` is combinational.
- Reset values: `reg_wr` = 0, `reg_wr_addr` = 0, `reg_wr_data` = 0, queue empty (count 0), `ld_issue_ready` = 1, `sb_stall` = 0.
- Reset mid-operation drops all queued loads. Responses for pre-reset loads are the memory's responsibility and must not arrive.

## Configuration
- `WB_BYPASS_EN` defined adds inputs `rf_a_addr`, `rf_b_addr` (5) and `rf_a_data`, `rf_b_data` (32), and outputs `byp_a_data`, `byp_b_data` (32).
  - `byp_x_data` = `reg_wr_data` when `reg_wr` && `reg_wr_addr` == `rf_x_addr` != 0; otherwise `rf_x_data`.
  - The in-flight write stage is excluded from `sb_stall`.
- `WB_BYPASS_EN` undefined: these ports are absent, and `sb_stall` covers the in-flight write stage.

## Structure
- Shared package `rv32_pkg`:
  - `XLEN` = 32 and `REG_ADDR_W` = 5.
  - Load funct3 enum `load_op_e` (LB, LH, LW, LBU, LHU).
  - Struct `ld_entry_t` {rd, funct3, offset}.
- One sub-module: `load_queue`, a parameterized FIFO with an exposed per-entry valid/rd vector for the scoreboard match.
- Alignment logic is a function in `rv32_pkg`.

## Test plan
- ALU write: `alu_valid`, rd = 5, result 0xDEADBEEF -> next cycle `reg_wr` = 1, addr 5, data 0xDEADBEEF. With rd = 0 -> `reg_wr` = 0.
- Load types: issue LB offset 3, response 0x80FF_1234 -> data 0xFFFFFF80. LHU offset 2 -> 0x000080FF. LW -> 0x80FF1234.
- Collision: `mem_rsp_valid` and `alu_valid` in the same cycle -> load written first, `alu_ready` = 0. ALU written the next cycle.
- Queue full: with MAX_OUTSTANDING = 2 and two issues pending, `ld_issue_ready` = 0. A response pops one, after which push+pop in the same cycle keeps count at 1.
- Scoreboard and WAW: load to x7 pending -> `sb_stall` = 1 for rs1 = 7 and `alu_ready` = 0 for `alu_rd` = 7. Both clear after the response (with `WB_BYPASS_EN`: `byp_a_data` returns the load data).
- Reset asserted with two loads queued -> all outputs 0, `ld_issue_ready` = 1, `sb_stall` = 0. A spurious response after reset produces no write.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 types for the writeback path: widths, load opcodes, queue entry
// layout and the load-data alignment helper.
package rv32_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_op_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            offset;
    } ld_entry_t;

    // Unlisted funct3 encodings fall through to a full-word load.
    function automatic logic [XLEN-1:0] load_align(input logic [2:0]      funct3,
                                                   input logic [1:0]      offset,
                                                   input logic [XLEN-1:0] word);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (load_op_e'(funct3))
            LB:      r = {{24{b[7]}}, b};
            LH:      r = {{16{h[15]}}, h};
            LBU:     r = {24'b0, b};
            LHU:     r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// Writeback unit bus: ALU result, load issue/response, scoreboard query and
// register-file write port. Optional bypass ports under WB_BYPASS_EN.
interface writeback_unit_if;
    import rv32_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_result;
    logic                  ld_issue_valid;
    logic                  ld_issue_ready;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic [2:0]            ld_issue_funct3;
    logic [1:0]            ld_issue_offset;
    logic                  mem_rsp_valid;
    logic [XLEN-1:0]       mem_rsp_data;
    logic [REG_ADDR_W-1:0] sb_rs1_addr;
    logic [REG_ADDR_W-1:0] sb_rs2_addr;
    logic                  sb_stall;
    logic                  reg_wr;
    logic [REG_ADDR_W-1:0] reg_wr_addr;
    logic [XLEN-1:0]       reg_wr_data;
`ifdef WB_BYPASS_EN
    logic [REG_ADDR_W-1:0] rf_a_addr;
    logic [REG_ADDR_W-1:0] rf_b_addr;
    logic [XLEN-1:0]       rf_a_data;
    logic [XLEN-1:0]       rf_b_data;
    logic [XLEN-1:0]       byp_a_data;
    logic [XLEN-1:0]       byp_b_data;
`endif

    modport slave (
`ifdef WB_BYPASS_EN
        input  rf_a_addr, rf_b_addr, rf_a_data, rf_b_data,
        output byp_a_data, byp_b_data,
`endif
        input  alu_valid, alu_rd, alu_result,
        input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_offset,
        input  mem_rsp_valid, mem_rsp_data, sb_rs1_addr, sb_rs2_addr,
        output alu_ready, ld_issue_ready, sb_stall, reg_wr, reg_wr_addr, reg_wr_data
    );

    modport master (
`ifdef WB_BYPASS_EN
        output rf_a_addr, rf_b_addr, rf_a_data, rf_b_data,
        input  byp_a_data, byp_b_data,
`endif
        output alu_valid, alu_rd, alu_result,
        output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_offset,
        output mem_rsp_valid, mem_rsp_data, sb_rs1_addr, sb_rs2_addr,
        input  alu_ready, ld_issue_ready, sb_stall, reg_wr, reg_wr_addr, reg_wr_data
    );
endinterface

// File: rtl/load_queue.sv
// In-order outstanding-load FIFO; exposes per-slot valid/rd so the scoreboard
// can match destinations without walking the pointers.
module load_queue
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  ld_entry_t                        push_entry,
    input  logic                             pop,
    output ld_entry_t                        head,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0]                 ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ld_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            // Push and pop never target the same slot: push needs !full, pop needs !empty.
            if (pop) begin
                rd_ptr          <= ptr_inc(rd_ptr);
                ent_vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr          <= ptr_inc(wr_ptr);
                ent_vld[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign ent_rd[i] = mem[i].rd;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: merges ALU results and in-order load
// responses, with a load scoreboard. Optional macro: WB_BYPASS_EN.
module writeback_unit
    import rv32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic             clk,
    input logic             rst_n,
    writeback_unit_if.slave bus
);
    ld_entry_t                                  q_head, q_push_entry;
    logic                                       q_full, q_empty, q_push, q_pop;
    logic [MAX_OUTSTANDING-1:0]                 q_vld;
    logic [MAX_OUTSTANDING-1:0][REG_ADDR_W-1:0] q_rd;

    logic                  wr_q;
    logic [REG_ADDR_W-1:0] wr_addr_q;
    logic [XLEN-1:0]       wr_data_q;
    logic                  alu_hit, rs1_hit, rs2_hit, rs1_wb, rs2_wb, alu_fire;

    assign q_push_entry = '{rd: bus.ld_issue_rd, funct3: bus.ld_issue_funct3,
                            offset: bus.ld_issue_offset};
    assign bus.ld_issue_ready = !q_full;
    assign q_push = bus.ld_issue_valid && !q_full;
    assign q_pop  = bus.mem_rsp_valid && !q_empty;

    load_queue #(.DEPTH(MAX_OUTSTANDING)) u_load_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .ent_vld    (q_vld),
        .ent_rd     (q_rd)
    );

    always_comb begin
        alu_hit = 1'b0;
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            alu_hit |= q_vld[i] && (q_rd[i] == bus.alu_rd);
            rs1_hit |= q_vld[i] && (q_rd[i] == bus.sb_rs1_addr);
            rs2_hit |= q_vld[i] && (q_rd[i] == bus.sb_rs2_addr);
        end
    end

    // A load response owns the write port; an ALU write to a pending load rd must wait (WAW).
    assign bus.alu_ready = !bus.mem_rsp_valid && !((bus.alu_rd != '0) && alu_hit);
    assign alu_fire      = bus.alu_valid && bus.alu_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (q_pop) begin
            wr_q      <= (q_head.rd != '0);
            wr_addr_q <= q_head.rd;
            wr_data_q <= load_align(q_head.funct3, q_head.offset, bus.mem_rsp_data);
        end else if (alu_fire) begin
            wr_q      <= (bus.alu_rd != '0);
            wr_addr_q <= bus.alu_rd;
            wr_data_q <= bus.alu_result;
        end else begin
            wr_q      <= 1'b0;
        end
    end

    assign bus.reg_wr      = wr_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;

`ifdef WB_BYPASS_EN
    // The in-flight write is forwarded, so it never needs to stall decode.
    assign rs1_wb = 1'b0;
    assign rs2_wb = 1'b0;
    assign bus.byp_a_data = (wr_q && wr_addr_q == bus.rf_a_addr && bus.rf_a_addr != '0)
                            ? wr_data_q : bus.rf_a_data;
    assign bus.byp_b_data = (wr_q && wr_addr_q == bus.rf_b_addr && bus.rf_b_addr != '0)
                            ? wr_data_q : bus.rf_b_data;
`else
    assign rs1_wb = wr_q && (wr_addr_q == bus.sb_rs1_addr);
    assign rs2_wb = wr_q && (wr_addr_q == bus.sb_rs2_addr);
`endif

    assign bus.sb_stall = ((bus.sb_rs1_addr != '0) && (rs1_hit || rs1_wb)) ||
                          ((bus.sb_rs2_addr != '0) && (rs2_hit || rs2_wb));
endmodule
